// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Receive FIFO sitting between a UART core receive side
//               (dv/q/rd handshake) and one CPU IO chip-select slot.
//               Received bytes are drained automatically into a 2**DEPTH_LOG2
//               deep buffer. The CPU pops bytes from DATA, reads occupancy
//               and flags from STATUS, and sets threshold / interrupt enable /
//               flush / overflow-clear through CONTROL. A registered level
//               interrupt fires when the fill level reaches the threshold.
// Ports       : clk    - system clock, rising edge
//               reset  - asynchronous, active-high reset
//               u_dv   - UART received-data-valid
//               u_q    - UART received byte
//               u_rd   - one-cycle read acknowledge back to the UART
//               cs     - IO chip-select
//               addr   - word offset: 0 DATA, 1 STATUS, 2 CONTROL, 3 reserved
//               mwe    - byte write strobes, 4'b0000 = read
//               wdata  - CPU write data
//               rdata  - combinational read data
//               irq    - level interrupt request
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        u_dv,
    input  logic [7:0]  u_q,
    output logic        u_rd,
    input  logic        cs,
    input  logic [1:0]  addr,
    input  logic [3:0]  mwe,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam int                  c_DEPTH     = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_DEPTH_CNT = (DEPTH_LOG2 + 1)'(c_DEPTH);
    // Threshold register is 5 bits wide; saturate the clamp value to fit.
    localparam logic [4:0]          c_THR_MAX   = (c_DEPTH > 31) ? 5'd31 : 5'(c_DEPTH);

    localparam logic [1:0] c_ADDR_DATA   = 2'd0;
    localparam logic [1:0] c_ADDR_STATUS = 2'd1;
    localparam logic [1:0] c_ADDR_CTRL   = 2'd2;

    // Storage and state
    logic [7:0]            r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_ovf;
    logic [4:0]            r_thr;
    logic                  r_ien;
    logic                  r_u_rd;
    logic                  r_guard;
    logic                  r_prev_read;
    logic                  r_irq;

    // Decoded strobes
    logic                  w_read;
    logic                  w_pop_req;
    logic                  w_ctrl_wr;
    logic                  w_flush;
    logic                  w_ovf_clr;
    logic                  w_capture;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_overflow;
    logic [DEPTH_LOG2:0]   w_count_next;
    logic                  w_ovf_next;
    logic [4:0]            w_thr_wr;
    logic                  w_irq_next;
    logic                  w_unused_bits;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_DEPTH_CNT);

    assign w_read    = cs & (addr == c_ADDR_DATA) & (mwe == 4'b0000);
    // Only the first cycle of a (possibly stretched) bus read pops.
    assign w_pop_req = w_read & ~r_prev_read;

    assign w_ctrl_wr = cs & (addr == c_ADDR_CTRL) & mwe[0];
    assign w_flush   = w_ctrl_wr & mwe[1] & wdata[9];
    assign w_ovf_clr = w_ctrl_wr & mwe[1] & wdata[10];

    // The UART keeps dv high until it sees our ack, so the ack cycle itself
    // and the cycle after it must not be taken as a new byte.
    assign w_capture = u_dv & ~r_u_rd & ~r_guard;

    // A flush wins over everything queued in the same cycle.
    assign w_pop      = w_pop_req & ~w_empty & ~w_flush;
    // When full, a same-cycle pop frees the slot the push needs.
    assign w_push     = w_capture & (~w_full | w_pop) & ~w_flush;
    assign w_overflow = w_capture & w_full & ~w_pop & ~w_flush;

    always_comb begin
        w_count_next = r_count;
        if (w_flush) begin
            w_count_next = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + 1'b1;
                2'b01:   w_count_next = r_count - 1'b1;
                default: w_count_next = r_count;
            endcase
        end
    end

    // Overflow set has priority over a same-cycle clear request.
    always_comb begin
        w_ovf_next = r_ovf;
        if (w_overflow) begin
            w_ovf_next = 1'b1;
        end else if (w_ovf_clr) begin
            w_ovf_next = 1'b0;
        end
    end

    // Threshold of zero would make the interrupt meaningless; treat it as 1.
    always_comb begin
        w_thr_wr = wdata[4:0];
        if (wdata[4:0] == 5'd0) begin
            w_thr_wr = 5'd1;
        end else if (32'(wdata[4:0]) > 32'(c_DEPTH)) begin
            w_thr_wr = c_THR_MAX;
        end
    end

    assign w_irq_next = r_ien & (32'(w_count_next) >= 32'(r_thr));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_thr       <= 5'd1;
            r_ien       <= 1'b0;
            r_u_rd      <= 1'b0;
            r_guard     <= 1'b0;
            r_prev_read <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_u_rd      <= w_capture;
            r_guard     <= r_u_rd;
            r_prev_read <= w_read;
            r_count     <= w_count_next;
            r_ovf       <= w_ovf_next;
            r_irq       <= w_irq_next;
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
            if (w_ctrl_wr) begin
                r_thr <= w_thr_wr;
                if (mwe[1]) begin
                    r_ien <= wdata[8];
                end
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= u_q;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            c_ADDR_DATA: begin
                if (!w_empty) begin
                    rdata[7:0] = r_mem[r_rd_ptr];
                end
            end
            c_ADDR_STATUS: begin
                rdata[8 +: DEPTH_LOG2 + 1] = r_count;
                rdata[2]                   = r_ovf;
                rdata[1]                   = w_full;
                rdata[0]                   = w_empty;
            end
            c_ADDR_CTRL: begin
                rdata[8]   = r_ien;
                rdata[4:0] = r_thr;
            end
            default: rdata = '0;
        endcase
    end

    assign u_rd = r_u_rd;
    assign irq  = r_irq;

    assign w_unused_bits = &{1'b0, wdata[31:11], wdata[7:5]};

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo. A queue-based model
//               tracks FIFO contents, flags and control registers; a negedge
//               compare process checks u_rd, irq and rdata every cycle, and
//               directed steps check hand-computed register values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        u_dv;
    logic [7:0]  u_q;
    logic        u_rd;
    logic        cs;
    logic [1:0]  addr;
    logic [3:0]  mwe;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_total = 0;
    int n_bad   = 0;

    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk   (clk),
        .reset (reset),
        .u_dv  (u_dv),
        .u_q   (u_q),
        .u_rd  (u_rd),
        .cs    (cs),
        .addr  (addr),
        .mwe   (mwe),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0] m_q [$];
    logic       m_ovf, m_ien, m_urd, m_guard, m_prev_rd, m_irq;
    logic [4:0] m_thr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_ovf = 0; m_ien = 0; m_urd = 0; m_guard = 0; m_prev_rd = 0; m_irq = 0;
            m_thr = 5'd1;
        end else begin
            bit cap, rd, pop, ctrl, flush, ovfset;
            cap    = u_dv && !m_urd && !m_guard;
            rd     = cs && addr == 2'd0 && mwe == 4'd0;
            pop    = rd && !m_prev_rd && m_q.size() > 0;
            ctrl   = cs && addr == 2'd2 && mwe[0];
            flush  = ctrl && mwe[1] && wdata[9];
            ovfset = 0;
            if (flush) begin
                m_q.delete();
            end else begin
                if (pop) void'(m_q.pop_front());
                if (cap) begin
                    if (m_q.size() < 16) m_q.push_back(u_q);
                    else ovfset = 1;
                end
            end
            m_irq = m_ien && (m_q.size() >= int'(m_thr));
            if (ovfset) m_ovf = 1;
            else if (ctrl && mwe[1] && wdata[10]) m_ovf = 0;
            if (ctrl) begin
                if (wdata[4:0] == 0) m_thr = 1;
                else if (wdata[4:0] > 16) m_thr = 16;
                else m_thr = wdata[4:0];
                if (mwe[1]) m_ien = wdata[8];
            end
            m_guard   = m_urd;
            m_urd     = cap;
            m_prev_rd = rd;
        end
    end

    function automatic logic [31:0] exp_rdata(input logic [1:0] a);
        logic [4:0] sz;
        sz = 5'(m_q.size());
        case (a)
            2'd0:    return (m_q.size() > 0) ? {24'h0, m_q[0]} : 32'h0;
            2'd1:    return {16'h0, 3'b0, sz, 5'b0, m_ovf, sz == 5'd16, sz == 5'd0};
            2'd2:    return {22'h0, m_ien, 3'b0, m_thr};
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("model u_rd", {31'h0, u_rd}, {31'h0, m_urd});
            chk("model irq", {31'h0, irq}, {31'h0, m_irq});
            if (cs) chk("model rdata", rdata, exp_rdata(addr));
        end
    end

    // ---------------- stimulus helpers (all start at posedge+1) ----------------
    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        u_q = b; u_dv = 1'b1;
        do begin
            @(posedge clk); #1; n++;
        end while (!u_rd && n < 10);
        chk("u_rd ack", {31'h0, u_rd}, 32'h1);
        u_dv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        cs = 1'b1; addr = a; mwe = 4'b0000;
        @(negedge clk);
        d = rdata;
        @(posedge clk); #1;
        cs = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic write_ctrl(input logic [3:0] m, input logic [31:0] wd);
        cs = 1'b1; addr = 2'd2; mwe = m; wdata = wd;
        @(posedge clk); #1;
        cs = 1'b0; mwe = 4'b0000; wdata = 32'h0;
    endtask

    task automatic expect_reg(input string nm, input logic [1:0] a, input logic [31:0] req);
        logic [31:0] d;
        read_reg(a, d);
        chk(nm, d, req);
    endtask

    initial begin
        reset = 1'b1; u_dv = 1'b0; u_q = 8'h0; cs = 1'b0; addr = 2'd0;
        mwe = 4'b0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        chk("reset irq", {31'h0, irq}, 32'h0);
        chk("reset u_rd", {31'h0, u_rd}, 32'h0);
        expect_reg("reset STATUS", 2'd1, 32'h0000_0001);
        expect_reg("reset CONTROL", 2'd2, 32'h0000_0001);

        // Basic ordering
        push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
        expect_reg("status count3", 2'd1, 32'h0000_0300);
        expect_reg("data 41", 2'd0, 32'h41);
        expect_reg("data 42", 2'd0, 32'h42);
        expect_reg("data 43", 2'd0, 32'h43);
        expect_reg("status empty", 2'd1, 32'h0000_0001);
        expect_reg("data when empty", 2'd0, 32'h0);

        // Fill and overflow
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        expect_reg("status full", 2'd1, 32'h0000_1002);
        push_byte(8'h10);
        expect_reg("status ovf", 2'd1, 32'h0000_1006);
        for (int i = 0; i < 16; i++) expect_reg("drain data", 2'd0, 32'(i));
        write_ctrl(4'b0011, 32'h400);
        expect_reg("ovf cleared", 2'd1, 32'h0000_0001);

        // Interrupt threshold
        write_ctrl(4'b0011, 32'h104);
        expect_reg("ctrl 104", 2'd2, 32'h0000_0104);
        push_byte(8'h61); push_byte(8'h62); push_byte(8'h63);
        chk("irq below thr", {31'h0, irq}, 32'h0);
        push_byte(8'h64);
        chk("irq at thr", {31'h0, irq}, 32'h1);
        expect_reg("irq pop data", 2'd0, 32'h61);
        chk("irq after pop", {31'h0, irq}, 32'h0);
        for (int i = 0; i < 3; i++) expect_reg("irq drain", 2'd0, 32'(8'h62 + i));
        write_ctrl(4'b0011, 32'h0);

        // Full + simultaneous push/pop
        for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i));
        expect_reg("status full2", 2'd1, 32'h0000_1002);
        u_q = 8'hAA; u_dv = 1'b1; cs = 1'b1; addr = 2'd0; mwe = 4'b0;
        @(posedge clk); #1;
        cs = 1'b0;
        chk("simul u_rd", {31'h0, u_rd}, 32'h1);
        u_dv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_reg("simul status", 2'd1, 32'h0000_1002);
        expect_reg("simul head", 2'd0, 32'h81);
        // Stretched 3-cycle read pops once
        cs = 1'b1; addr = 2'd0; mwe = 4'b0;
        repeat (3) @(posedge clk);
        #1 cs = 1'b0;
        @(posedge clk); #1;
        expect_reg("long read count", 2'd1, 32'h0000_0E00);
        expect_reg("long read head", 2'd0, 32'h83);
        for (int i = 0; i < 8; i++) expect_reg("drain to 5", 2'd0, 32'(8'h84 + i));
        expect_reg("five left", 2'd1, 32'h0000_0500);

        // Flush with a byte arriving in the same cycle
        u_q = 8'h55; u_dv = 1'b1;
        cs = 1'b1; addr = 2'd2; mwe = 4'b0011; wdata = 32'h200;
        @(posedge clk); #1;
        cs = 1'b0; mwe = 4'b0; wdata = 32'h0;
        chk("flush u_rd", {31'h0, u_rd}, 32'h1);
        u_dv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_reg("flush status", 2'd1, 32'h0000_0001);
        expect_reg("flush ctrl", 2'd2, 32'h0000_0001);

        // Threshold clamp; ien untouched without mwe[1]
        write_ctrl(4'b0001, 32'h11F);
        expect_reg("thr clamp", 2'd2, 32'h0000_0010);

        // Reset during a push
        u_q = 8'h77; u_dv = 1'b1;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("reset cuts u_rd", {31'h0, u_rd}, 32'h0);
        u_dv = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        expect_reg("post-reset STATUS", 2'd1, 32'h0000_0001);
        expect_reg("post-reset CONTROL", 2'd2, 32'h0000_0001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
